// File: rtl/eeg_sample_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : eeg_sample_loader_pkg
// Purpose  : Shared types and constants for the EEG clip loader.
// Revision : 1.0 - initial release
// ============================================================================
package eeg_sample_loader_pkg;

    localparam int ADC_BITWIDTH         = 16;
    localparam int Q_STO_INT_RES_DOUBLE = 20;
    localparam int NUM_PATCHES          = 60;
    localparam int PATCH_LEN            = 64;
    localparam int NUM_EEG_SAMPLES      = NUM_PATCHES * PATCH_LEN;
    localparam int EEG_SHIFT            = Q_STO_INT_RES_DOUBLE - ADC_BITWIDTH;

    typedef logic [ADC_BITWIDTH-1:0] AdcData_t;
    typedef logic [15:0]             IntResAddr_t;
    typedef logic [29:0]             IntResDouble_t;

    typedef enum logic {
        SINGLE_WIDTH = 1'b0,
        DOUBLE_WIDTH = 1'b1
    } DataWidth_t;

    typedef enum logic [1:0] {
        INT_RES_SW_FX = 2'd0,
        INT_RES_DW_FX = 2'd1
    } FxFormatIntRes_t;

    localparam IntResAddr_t EEG_INPUT_MEM_BASE = 16'h0000;

    typedef enum logic [1:0] {
        EEG_IDLE  = 2'd0,
        EEG_LOAD  = 2'd1,
        EEG_DRAIN = 2'd2,
        EEG_DONE  = 2'd3
    } EegLoadState_t;

    // Unsigned ADC code becomes adc/2^16 with 20 fractional bits; never negative.
    function automatic IntResDouble_t eeg_to_int_res(input AdcData_t s);
        return IntResDouble_t'(s) << EEG_SHIFT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eeg_sample_loader_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with occupancy count; push when full is dropped
//            unless a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/eeg_sample_loader.sv
`default_nettype none
// ============================================================================
// Module   : eeg_sample_loader
// Purpose  : Buffers one EEG clip of ADC samples and writes them, converted to
//            double-width fixed point, to consecutive IntRes addresses.
// Revision : 1.0 - initial release
// ============================================================================
import eeg_sample_loader_pkg::*;

module eeg_sample_loader #(
    parameter int          FIFO_DEPTH  = 4,
    parameter int          NUM_SAMPLES = NUM_EEG_SAMPLES,
    parameter IntResAddr_t BASE_ADDR   = EEG_INPUT_MEM_BASE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_load,
    input  logic            new_sample,
    input  AdcData_t        adc_data,
    output logic            wr_en,
    output IntResAddr_t     wr_addr,
    output IntResDouble_t   wr_data,
    output DataWidth_t      wr_width,
    output FxFormatIntRes_t wr_format,
    input  logic            wr_gnt,
    output logic            busy,
    output logic            done,
    output logic            overflow,
    output logic [11:0]     sample_cnt
);

    localparam int              FCW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [11:0]     LAST_CNT = 12'(NUM_SAMPLES - 1);
    localparam logic [11:0]     FULL_CNT = 12'(NUM_SAMPLES);

    EegLoadState_t  state;
    EegLoadState_t  next_state;
    logic [11:0]    acc_cnt;
    logic [11:0]    addr_idx;
    logic           load_active;
    logic           sample_in;
    logic           accept;
    logic           drop;
    logic           fifo_clr;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FCW-1:0] fifo_count;
    AdcData_t       fifo_head;

    assign load_active = (state == EEG_LOAD) || (state == EEG_DRAIN);
    assign sample_in   = (state == EEG_LOAD) && new_sample;
    assign wr_en       = load_active && !fifo_empty;
    assign fifo_pop    = wr_en && wr_gnt;
    // A full FIFO still takes a sample when the head retires in the same cycle.
    assign accept      = sample_in && (!fifo_full || fifo_pop);
    assign drop        = sample_in && fifo_full && !fifo_pop;
    assign fifo_clr    = (state == EEG_IDLE) && start_load;

    sync_fifo #(
        .WIDTH (ADC_BITWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push  (accept),
        .pop   (fifo_pop),
        .din   (adc_data),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EEG_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            EEG_IDLE: begin
                if (start_load) begin
                    next_state = EEG_LOAD;
                end
            end
            EEG_LOAD: begin
                if (accept && (acc_cnt == LAST_CNT)) begin
                    next_state = EEG_DRAIN;
                end
            end
            EEG_DRAIN: begin
                // No pushes in DRAIN, so the entry popped at count 1 is the last.
                if (fifo_pop && (fifo_count == FCW'(1))) begin
                    next_state = EEG_DONE;
                end
            end
            EEG_DONE: begin
                next_state = EEG_IDLE;
            end
            default: begin
                next_state = EEG_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt    <= '0;
            sample_cnt <= '0;
            overflow   <= 1'b0;
        end else if (fifo_clr) begin
            acc_cnt    <= '0;
            sample_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            if (accept && (acc_cnt != FULL_CNT)) begin
                acc_cnt <= acc_cnt + 12'd1;
            end
            if (fifo_pop && (sample_cnt != FULL_CNT)) begin
                sample_cnt <= sample_cnt + 12'd1;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // sample_cnt rests at NUM_SAMPLES after a clip; keep the address in range.
    assign addr_idx  = (sample_cnt > LAST_CNT) ? LAST_CNT : sample_cnt;
    assign wr_addr   = BASE_ADDR + IntResAddr_t'(addr_idx);
    assign wr_data   = wr_en ? eeg_to_int_res(fifo_head) : '0;
    assign wr_width  = DOUBLE_WIDTH;
    assign wr_format = INT_RES_DW_FX;
    assign busy      = load_active;
    assign done      = (state == EEG_DONE);

endmodule
`default_nettype wire

// File: tb/tb_eeg_sample_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_eeg_sample_loader
// Purpose  : Randomised scoreboard bench for eeg_sample_loader.
// Revision : 1.0 - initial release
// ============================================================================
import eeg_sample_loader_pkg::*;

module tb_eeg_sample_loader;

    localparam int          DEPTH = 4;
    localparam int          N     = NUM_EEG_SAMPLES;
    localparam logic [15:0] BASE  = 16'h0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_load = 1'b0;
    logic            new_sample = 1'b0;
    logic [15:0]     adc_data = '0;
    logic            wr_gnt = 1'b0;
    logic            wr_en;
    logic [15:0]     wr_addr;
    logic [29:0]     wr_data;
    DataWidth_t      wr_width;
    FxFormatIntRes_t wr_format;
    logic            busy;
    logic            done;
    logic            overflow;
    logic [11:0]     sample_cnt;

    eeg_sample_loader #(
        .FIFO_DEPTH  (DEPTH),
        .NUM_SAMPLES (N),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_load (start_load),
        .new_sample (new_sample),
        .adc_data   (adc_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_width   (wr_width),
        .wr_format  (wr_format),
        .wr_gnt     (wr_gnt),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [29:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    // Reference model: clip progress in terms of accepted / pending / written samples.
    bit  m_busy = 0;
    bit  m_done = 0;
    bit  m_ovf  = 0;
    int  m_acc = 0;
    int  m_pend = 0;
    int  m_written = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Write monitor: every retired write must match the scoreboard head.
    wr_t         mon_e;
    logic        hold_v = 1'b0;
    logic [15:0] hold_a;
    logic [29:0] hold_d;

    always @(negedge clk) begin
        if (rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_wr_en", {31'b0, wr_en}, 32'd1);
                chk("hold_wr_addr", {16'b0, wr_addr}, {16'b0, hold_a});
                chk("hold_wr_data", {2'b0, wr_data}, {2'b0, hold_d});
            end
            if (wr_en && wr_gnt) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: addr %0h data %0h, expected no write", wr_addr, wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
                        miscompares++;
                        $display("FAIL write: got addr %0h data %0h, expected addr %0h data %0h",
                                 wr_addr, wr_data, mon_e.addr, mon_e.data);
                    end
                end
            end
            hold_v = wr_en && !wr_gnt;
            hold_a = wr_addr;
            hold_d = wr_data;
        end
    end

    task automatic model_update(input bit ns, input logic [15:0] adc, input bit gnt, input bit st);
        bit pop;
        if (m_done) begin
            m_done = 0;
        end else if (!m_busy) begin
            if (st) begin
                m_busy = 1; m_acc = 0; m_pend = 0; m_written = 0; m_ovf = 0;
            end
        end else begin
            pop = gnt && (m_pend > 0);
            if (ns && m_acc < N) begin
                if (m_pend < DEPTH || pop) begin
                    exp_q.push_back('{addr: BASE + 16'(m_acc), data: {10'b0, adc, 4'b0}});
                    m_acc++;
                    m_pend++;
                end else begin
                    m_ovf = 1;
                end
            end
            if (pop) begin
                m_pend--;
                m_written++;
                if (m_written == N) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
    endtask

    task automatic step(input bit ns, input logic [15:0] adc, input bit gnt, input bit st);
        new_sample = ns;
        adc_data   = adc;
        wr_gnt     = gnt;
        start_load = st;
        @(negedge clk);
        chk("busy", {31'b0, busy}, {31'b0, m_busy});
        chk("done", {31'b0, done}, {31'b0, m_done});
        chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
        chk("sample_cnt", {20'b0, sample_cnt}, 32'(m_written));
        #1;
        model_update(ns, adc, gnt, st);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, {31'b0, wr_en}, 32'd0);
        chk({tag, "_wr_addr"}, {16'b0, wr_addr}, {16'b0, BASE});
        chk({tag, "_wr_data"}, {2'b0, wr_data}, 32'd0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_overflow"}, {31'b0, overflow}, 32'd0);
        chk({tag, "_sample_cnt"}, {20'b0, sample_cnt}, 32'd0);
        chk({tag, "_wr_width"}, {31'b0, wr_width}, {31'b0, DOUBLE_WIDTH});
        chk({tag, "_wr_format"}, {30'b0, wr_format}, {30'b0, INT_RES_DW_FX});
    endtask

    task automatic do_reset(input string tag);
        new_sample = 0; start_load = 0; wr_gnt = 0; adc_data = '0;
        rst = 1'b1;
        #1;
        check_reset_outputs(tag);
        m_busy = 0; m_done = 0; m_ovf = 0; m_acc = 0; m_pend = 0; m_written = 0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic expect_done(input string tag, input int cyc, input int limit);
        if (cyc >= limit) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout_%s: %0d cycles without completion, written %0d of %0d",
                     tag, cyc, m_written, N);
            do_reset({tag, "_recover"});
        end else begin
            step(0, 16'h0, 1, 0);   // the done cycle
            step(0, 16'h0, 1, 0);
            chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        int i;
        int cyc;
        bit ns;
        bit g;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Nominal clip: adc=i every third cycle, grant always high.
        step(1, 16'h1234, 1, 0);          // sample in IDLE is ignored
        step(1, 16'hBEEF, 1, 1);          // start with a coincident sample: not captured
        i = 0; cyc = 0;
        while (!m_done && cyc < 20000) begin
            ns = (cyc % 3 == 0);
            step(ns, (i < N) ? 16'(i) : 16'hDEAD, 1, cyc == 500);
            if (ns) i++;
            cyc++;
        end
        chk("nominal_overflow", {31'b0, overflow}, 32'd0);
        expect_done("nominal", cyc, 20000);

        // Backpressure: grant low for 10 cycles with 6 back-to-back samples.
        step(0, 16'h0, 0, 1);
        for (int k = 0; k < 10; k++) begin
            step(k < 6, (k == 0) ? 16'hFFFF : (k == 1) ? 16'h0000 : 16'($urandom), 0, 0);
        end
        chk("bp_overflow", {31'b0, overflow}, 32'd1);
        chk("bp_sample_cnt", {20'b0, sample_cnt}, 32'd0);
        cyc = 0;
        while (!m_done && cyc < 40000) begin
            g  = ($urandom_range(0, 1) == 1);
            ns = ($urandom_range(0, 9) < 4);
            step(ns, 16'($urandom), g, ($urandom_range(0, 99) == 0));
            cyc++;
        end
        expect_done("random", cyc, 40000);
        chk("overflow_sticky_idle", {31'b0, overflow}, 32'd1);

        // Reset in the middle of a clip.
        step(0, 16'h0, 1, 1);
        cyc = 0;
        while (m_written < 100 && cyc < 2000) begin
            step(cyc % 2 == 0, 16'($urandom), $urandom_range(0, 3) != 0, 0);
            cyc++;
        end
        do_reset("midload");
        for (int k = 0; k < 5; k++) step(1, 16'hAAAA, 1, 0);

        // Restart from address 0: fill the FIFO, then push and pop every cycle.
        step(0, 16'h0, 0, 1);
        for (int k = 0; k < DEPTH; k++) step(1, 16'($urandom), 0, 0);
        cyc = 0;
        while (!m_done && cyc < 8000) begin
            step(1, 16'($urandom), 1, cyc == 37);
            cyc++;
        end
        chk("pushpop_overflow", {31'b0, overflow}, 32'd0);
        expect_done("pushpop", cyc, 8000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/eeg_sample_loader.md
Name: eeg_sample_loader

Overview:
- Front-end stage that fills the intermediate-result memory with one EEG clip before inference starts.
- Active during the EEG_LOAD state. Accepts 16b unsigned ADC samples through a pulse handshake and buffers them in a small FIFO.
- Converts each sample to the double-width fixed-point storage format and writes it to consecutive IntRes addresses starting at mem_map[EEG_INPUT_MEM].
- Reports completion to the top-level controller once NUM_PATCHES*PATCH_LEN samples are stored.

Parameters:
- FIFO_DEPTH, 4, sample skid-buffer entries (power of 2, >=2)
- NUM_SAMPLES, NUM_PATCHES*PATCH_LEN (3840), samples per clip
- BASE_ADDR, mem_map[EEG_INPUT_MEM] (0), first write address

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start_load  in  1  one-cycle pulse from controller; begins a clip load
- new_sample  in  1  one-cycle pulse; adc_data valid this cycle
- adc_data  in  AdcData_t (16)  unsigned ADC sample
- wr_en  out  1  memory write request
- wr_addr  out  IntResAddr_t (16)  write address
- wr_data  out  IntResDouble_t (30)  converted sample
- wr_width  out  DataWidth_t  constant DOUBLE_WIDTH
- wr_format  out  FxFormatIntRes_t  constant int_res_format[EEG_FORMAT] (INT_RES_DW_FX)
- wr_gnt  in  1  memory arbiter grant; write retires when wr_en && wr_gnt
- busy  out  1  high from accepted start_load until done
- done  out  1  one-cycle pulse after the last write retires
- overflow  out  1  sticky; a sample was dropped because the FIFO was full
- sample_cnt  out  12  samples written in the current clip

Behaviour:
- Reset (async, rst=1): state IDLE, FIFO emptied, counters 0, every output 0 except wr_width=DOUBLE_WIDTH and wr_format=INT_RES_DW_FX. A reset mid-load abandons the clip with no done pulse.
- State machine has four states: IDLE, LOAD, DRAIN, DONE.
  - IDLE: start_load -> LOAD. On that transition: clear sample_cnt, clear the write pointer, clear overflow, assert busy next cycle. new_sample is ignored in IDLE.
  - LOAD: new_sample pushes adc_data into the FIFO. Once NUM_SAMPLES samples have been accepted -> DRAIN. Further new_sample pulses are ignored and do not set overflow.
  - DRAIN: writes out the remaining FIFO entries. When the last write retires -> DONE.
  - DONE: done=1 for exactly one cycle, busy drops in the same cycle, then -> IDLE.
- start_load is ignored while busy. When start_load and new_sample arrive in the same cycle in IDLE, that sample is not captured.
- Conversion: wr_data = {10'b0, adc_data, 4'b0}, i.e. adc << (Q_STO_INT_RES_DOUBLE - ADC_BITWIDTH).
  - Represents adc/2^16 in [0,1) with 20 fractional bits.
  - Always non-negative; no saturation is needed.
- Write path:
  - wr_en is asserted while the FIFO is non-empty and the state is LOAD or DRAIN.
  - wr_data is driven from the FIFO head. wr_addr = BASE_ADDR + sample_cnt.
  - wr_en, wr_addr and wr_data hold stable until wr_gnt. On retire: pop the FIFO, increment sample_cnt.
  - Latency: a sample accepted in cycle N can appear on wr_en in cycle N+1 at the earliest. At most one write retires per cycle.
- FIFO:
  - Push and pop in the same cycle are both honoured, and occupancy is unchanged.
  - A push when full and not popping drops the sample and sets overflow. The accepted-sample count does not advance.
  - The loader therefore waits for NUM_SAMPLES accepted samples, and overflow alerts the controller.
- Counters: the accepted count and sample_cnt stop at NUM_SAMPLES and never wrap. The write address never exceeds BASE_ADDR+NUM_SAMPLES-1.

Decomposition:
- Shared package additions:
  - NUM_EEG_SAMPLES constant (NUM_PATCHES*PATCH_LEN)
  - EegLoadState_t enum {EEG_IDLE, EEG_LOAD, EEG_DRAIN, EEG_DONE}
  - EEG_SHIFT constant (Q_STO_INT_RES_DOUBLE - ADC_BITWIDTH)
- Existing types reused: IntResAddr_t, IntResDouble_t, AdcData_t, DataWidth_t, FxFormatIntRes_t.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/count). It is reusable elsewhere.

Test Plan:
- Nominal load: start_load, wr_gnt=1, 3840 new_sample pulses every 3 cycles with adc=i -> write i lands at addr i with data i<<4; done pulses once exactly 1 cycle after write 3839 retires; overflow=0.
- Conversion edges: adc=16'hFFFF -> wr_data=30'h000FFFF0; adc=0 -> wr_data=0.
- Backpressure/overflow (FIFO_DEPTH=4): wr_gnt=0 for 10 cycles, 6 back-to-back samples -> first 4 written in order once the grant returns, samples 5-6 dropped, overflow=1 and held until the next start_load, accepted count=4.
- Simultaneous push/pop: full FIFO, wr_gnt=1, new_sample every cycle -> no drop, overflow stays 0, one write per cycle.
- Ignored events: new_sample in IDLE -> no wr_en; start_load while busy -> sample_cnt not cleared; samples after 3840 -> no extra writes.
- Reset mid-load: rst asserted after 100 writes -> all outputs return to reset values immediately, no done; a new start_load then restarts at addr 0.
